// File: rtl/bcd_dec_arbiter_pkg.sv
// rtl/bcd_dec_arbiter_pkg.sv - shared types and constants for the BCD decoder arbiter
package bcd_dec_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CONV = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam logic [5:0] BCD_MAX_BIN  = 6'd39;
  localparam logic [5:0] BCD_ERR_CODE = 6'h3F;

endpackage

// File: rtl/bcd_dec_arbiter_if.sv
// rtl/bcd_dec_arbiter_if.sv - requester handshake and decoder port bundle
interface bcd_dec_arbiter_if;
  logic       req_a;
  logic       req_b;
  logic [5:0] bin_a;
  logic [5:0] bin_b;
  logic       ack_a;
  logic       ack_b;
  logic [5:0] bcd_out;
  logic       err;
  logic       gnt;
  logic       busy;
  logic       dec_g_n;
  logic [5:0] dec_bin;
  logic [5:0] dec_bcd;

  modport master (
    output req_a, req_b, bin_a, bin_b, dec_bcd,
    input  ack_a, ack_b, bcd_out, err, gnt, busy, dec_g_n, dec_bin
  );

  modport slave (
    input  req_a, req_b, bin_a, bin_b, dec_bcd,
    output ack_a, ack_b, bcd_out, err, gnt, busy, dec_g_n, dec_bin
  );
endinterface

// File: rtl/bcd_dec_arbiter_rr_arb2.sv
// rtl/bcd_dec_arbiter_rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2
  import bcd_dec_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = req_a | req_b;
  // On contention the requester not served last wins
  assign grant_id    = (req_a & req_b) ? ~last : (req_b ? REQ_B : REQ_A);

endmodule

// File: rtl/bcd_dec_arbiter.sv
// rtl/bcd_dec_arbiter.sv - round-robin sequencer for the shared 6-bit binary-to-BCD decoder
// Optional operand range check: BCD_ARB_RANGE_CHECK_EN
module bcd_dec_arbiter
  import bcd_dec_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
)
(
  input logic              clk,
  input logic              reset,
  bcd_dec_arbiter_if.slave bus
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t     state;
  logic [3:0] cnt;
  logic       last;
  logic       gnt_q;
  logic       ack_a_q;
  logic       ack_b_q;
  logic       busy_q;
  logic       dec_g_n_q;
  logic [5:0] dec_bin_q;
  logic [5:0] bcd_q;
  logic       grant_valid;
  logic       grant_id;
  logic [5:0] win_bin;

  rr_arb2 u_arb (
    .req_a       (bus.req_a),
    .req_b       (bus.req_b),
    .last        (last),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign win_bin = (grant_id == REQ_B) ? bus.bin_b : bus.bin_a;

`ifdef BCD_ARB_RANGE_CHECK_EN
  logic err_q;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last      <= REQ_B;
      gnt_q     <= REQ_A;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      busy_q    <= 1'b0;
      dec_g_n_q <= 1'b1;
      dec_bin_q <= 6'd0;
      bcd_q     <= 6'd0;
`ifdef BCD_ARB_RANGE_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            gnt_q  <= grant_id;
            busy_q <= 1'b1;
`ifdef BCD_ARB_RANGE_CHECK_EN
            // Out-of-range operands never reach the decoder
            if (win_bin > BCD_MAX_BIN) begin
              bcd_q   <= BCD_ERR_CODE;
              err_q   <= 1'b1;
              ack_a_q <= (grant_id == REQ_A);
              ack_b_q <= (grant_id == REQ_B);
              last    <= grant_id;
              state   <= DONE;
            end else begin
              dec_bin_q <= win_bin;
              dec_g_n_q <= 1'b0;
              cnt       <= WAIT_INIT;
              state     <= CONV;
            end
`else
            dec_bin_q <= win_bin;
            dec_g_n_q <= 1'b0;
            cnt       <= WAIT_INIT;
            state     <= CONV;
`endif
          end
        end
        CONV: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            bcd_q     <= bus.dec_bcd;
`ifdef BCD_ARB_RANGE_CHECK_EN
            err_q     <= 1'b0;
`endif
            ack_a_q   <= (gnt_q == REQ_A);
            ack_b_q   <= (gnt_q == REQ_B);
            dec_g_n_q <= 1'b1;
            last      <= gnt_q;
            state     <= DONE;
          end
        end
        DONE: begin
          ack_a_q <= 1'b0;
          ack_b_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack_a   = ack_a_q;
  assign bus.ack_b   = ack_b_q;
  assign bus.bcd_out = bcd_q;
  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.dec_g_n = dec_g_n_q;
  assign bus.dec_bin = dec_bin_q;

endmodule

// File: tb/tb_bcd_dec_arbiter.sv
// tb/tb_bcd_dec_arbiter.sv - self-checking bench for bcd_dec_arbiter with a behavioural decoder
module tb_bcd_dec_arbiter;

  localparam int W = 1;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ack_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_dec_arbiter_if bus ();
  bcd_dec_arbiter_if bus0 ();

  bcd_dec_arbiter #(.WAIT_CYCLES(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  bcd_dec_arbiter #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  // Decoder model: tens in [5:4], ones in [3:0]
  function automatic logic [5:0] to_bcd(input logic [5:0] v);
    int iv;
    int t;
    int o;
    iv = int'(v);
    t  = iv / 10;
    o  = iv % 10;
    return {t[1:0], o[3:0]};
  endfunction

  assign bus.dec_bcd  = bus.dec_g_n  ? 6'h00 : to_bcd(bus.dec_bin);
  assign bus0.dec_bcd = bus0.dec_g_n ? 6'h00 : to_bcd(bus0.dec_bin);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for one conversion on the main instance and check it end to end
  task automatic serve(input string tag, input logic exp_id, input logic [5:0] exp_bin,
                       input logic [5:0] exp_bcd, input logic [1:0] drop);
    int lat;
    int glow;
    logic [5:0] dbin;
    logic aa;
    logic ab;
    lat = -1; glow = 0; dbin = 6'd0; aa = 1'b0; ab = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!bus.dec_g_n) begin
        glow++;
        dbin = bus.dec_bin;
      end
      if (bus.ack_a || bus.ack_b) begin
        lat = n - 1;
        aa  = bus.ack_a;
        ab  = bus.ack_b;
        break;
      end
    end
    ack_cyc = cyc;
    check({tag, ".latency"}, lat, W + 1);
    check({tag, ".g_n_low"}, glow, W + 1);
    check({tag, ".dec_bin"}, 32'(dbin), 32'(exp_bin));
    check({tag, ".ack_a"}, 32'(aa), 32'(exp_id == 1'b0));
    check({tag, ".ack_b"}, 32'(ab), 32'(exp_id == 1'b1));
    check({tag, ".bcd_out"}, 32'(bus.bcd_out), 32'(exp_bcd));
    check({tag, ".gnt"}, 32'(bus.gnt), 32'(exp_id));
    check({tag, ".err"}, 32'(bus.err), 32'd0);
    if (drop[0]) bus.req_a = 1'b0;
    if (drop[1]) bus.req_b = 1'b0;
    @(negedge clk);
    check({tag, ".ack_fall"}, 32'({bus.ack_a, bus.ack_b}), 32'd0);
    check({tag, ".busy_idle"}, 32'(bus.busy), 32'd0);
  endtask

  int prev_ack;
  logic pend_a, pend_b, last_m, win;
  logic [5:0] bin_a_m, bin_b_m;
  int lat0, glow0;

  initial begin
    bus.req_a = 1'b0; bus.req_b = 1'b0; bus.bin_a = 6'd0; bus.bin_b = 6'd0;
    bus0.req_a = 1'b0; bus0.req_b = 1'b0; bus0.bin_a = 6'd0; bus0.bin_b = 6'd0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.dec_g_n", 32'(bus.dec_g_n), 32'd1);
    check("rst.dec_bin", 32'(bus.dec_bin), 32'd0);
    check("rst.bcd_out", 32'(bus.bcd_out), 32'd0);
    check("rst.err", 32'(bus.err), 32'd0);
    check("rst.acks", 32'({bus.ack_a, bus.ack_b}), 32'd0);
    check("rst.gnt", 32'(bus.gnt), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle.busy", 32'(bus.busy), 32'd0);

    // Single A request
    bus.bin_a = 6'd25; bus.req_a = 1'b1;
    serve("a25", 1'b0, 6'd25, 6'b100101, 2'b01);

    // B twice in a row without contention
    bus.bin_b = 6'd39; bus.req_b = 1'b1;
    serve("b39", 1'b1, 6'd39, 6'b111001, 2'b10);
    bus.bin_b = 6'd0; bus.req_b = 1'b1;
    serve("b0", 1'b1, 6'd0, 6'b000000, 2'b10);

    // Continuous contention alternates A,B,A,B at W+3 spacing
    bus.bin_a = 6'd9; bus.bin_b = 6'd10; bus.req_a = 1'b1; bus.req_b = 1'b1;
    serve("rr0", 1'b0, 6'd9, 6'b001001, 2'b00);
    prev_ack = ack_cyc;
    serve("rr1", 1'b1, 6'd10, 6'b010000, 2'b00);
    check("rr1.spacing", ack_cyc - prev_ack, W + 3);
    prev_ack = ack_cyc;
    serve("rr2", 1'b0, 6'd9, 6'b001001, 2'b00);
    check("rr2.spacing", ack_cyc - prev_ack, W + 3);
    prev_ack = ack_cyc;
    serve("rr3", 1'b1, 6'd10, 6'b010000, 2'b11);
    check("rr3.spacing", ack_cyc - prev_ack, W + 3);

    // Reset during CONV aborts without an ack; A then wins a tie
    bus.bin_a = 6'd7; bus.req_a = 1'b1;
    @(negedge clk);
    check("abort.conv_g_n", 32'(bus.dec_g_n), 32'd0);
    reset = 1'b1;
    #1;
    check("abort.dec_g_n", 32'(bus.dec_g_n), 32'd1);
    check("abort.busy", 32'(bus.busy), 32'd0);
    bus.bin_b = 6'd12; bus.req_b = 1'b1;
    @(negedge clk);
    check("abort.no_ack", 32'({bus.ack_a, bus.ack_b}), 32'd0);
    reset = 1'b0;
    serve("post_a", 1'b0, 6'd7, 6'b000111, 2'b01);
    serve("post_b", 1'b1, 6'd12, 6'b010010, 2'b10);

    // Random traffic against a round-robin model
    pend_a = 1'b0; pend_b = 1'b0; last_m = 1'b1;
    bin_a_m = 6'd0; bin_b_m = 6'd0;
    for (int i = 0; i < 30; i++) begin
      if (!pend_a && $urandom_range(0, 1) == 1) begin
        pend_a = 1'b1; bin_a_m = 6'($urandom_range(0, 39));
        bus.bin_a = bin_a_m; bus.req_a = 1'b1;
      end
      if (!pend_b && ($urandom_range(0, 1) == 1 || !pend_a)) begin
        pend_b = 1'b1; bin_b_m = 6'($urandom_range(0, 39));
        bus.bin_b = bin_b_m; bus.req_b = 1'b1;
      end
      win = (pend_a && pend_b) ? ~last_m : pend_b;
      serve($sformatf("rnd%0d", i), win, win ? bin_b_m : bin_a_m,
            to_bcd(win ? bin_b_m : bin_a_m), win ? 2'b10 : 2'b01);
      if (win) pend_b = 1'b0; else pend_a = 1'b0;
      last_m = win;
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    repeat (W + 4) @(negedge clk);

`ifdef BCD_ARB_RANGE_CHECK_EN
    bus.bin_a = 6'd45; bus.req_a = 1'b1;
    @(negedge clk);
    check("rng.ack_a", 32'(bus.ack_a), 32'd1);
    check("rng.err", 32'(bus.err), 32'd1);
    check("rng.bcd_out", 32'(bus.bcd_out), 32'h3F);
    check("rng.dec_g_n", 32'(bus.dec_g_n), 32'd1);
    bus.req_a = 1'b0;
    @(negedge clk);
    check("rng.ack_fall", 32'(bus.ack_a), 32'd0);
    check("rng.g_n_idle", 32'(bus.dec_g_n), 32'd1);
`endif

    // Zero settle cycles on the second instance
    bus0.bin_b = 6'd20; bus0.req_b = 1'b1;
    lat0 = -1; glow0 = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!bus0.dec_g_n) glow0++;
      if (bus0.ack_b) begin
        lat0 = n - 1;
        break;
      end
    end
    check("w0.latency", lat0, 1);
    check("w0.g_n_low", glow0, 1);
    check("w0.bcd_out", 32'(bus0.bcd_out), 32'(6'b100000));
    check("w0.gnt", 32'(bus0.gnt), 32'd1);
    bus0.req_b = 1'b0;
    @(negedge clk);
    check("w0.ack_fall", 32'(bus0.ack_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
